// File: rtl/bitmap_reader_if.sv
// rtl/bitmap_reader_if.sv - memory read master and pixel stream bundle for bitmap_reader
interface bitmap_reader_if;
   logic        mread;
   logic [18:0] maddress;
   logic [31:0] mreaddata;
   logic        mwaitrequest;
   logic        mreaddatavalid;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_data;
   logic        pix_sof;
   logic        pix_eol;

   modport master (
      output mread, maddress,
      input  mreaddata, mwaitrequest, mreaddatavalid,
      output pix_valid, pix_data, pix_sof, pix_eol,
      input  pix_ready
   );

   modport slave (
      input  mread, maddress,
      output mreaddata, mwaitrequest, mreaddatavalid,
      input  pix_valid, pix_data, pix_sof, pix_eol,
      output pix_ready
   );
endinterface

// File: rtl/bitmap_reader.sv
// rtl/bitmap_reader.sv - streams bitmap rows from the plotter slave as an LSB-first pixel stream
// Optional feature macro: BITMAP_READER_STATUS_POLL_EN (poll engine status word before fetching).
module bitmap_reader #(
   parameter int FIFO_DEPTH = 4,
   parameter int COLS_BYTES = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [8:0]      row_first,
   input  logic [8:0]      row_last,
   output logic            busy,
   output logic            done,
   bitmap_reader_if.master bus
);
   localparam int              PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              NW          = $clog2(FIFO_DEPTH + 1);
   localparam logic [5:0]      LAST_COL    = 6'(COLS_BYTES - 1);
   localparam logic [PW-1:0]   LAST_PTR    = PW'(FIFO_DEPTH - 1);
   localparam logic [18:0]     STATUS_ADDR = 19'h40000;

   typedef enum logic [2:0] {
      IDLE,
`ifdef BITMAP_READER_STATUS_POLL_EN
      POLL_REQ,
      POLL_WAIT,
`endif
      FETCH,
      FINISH
   } state_t;

   state_t        state, state_nx;
   logic [8:0]    rd_row, row_last_q;
   logic [5:0]    rd_col, out_col;
   logic          issue_done, first_row;
   logic [NW-1:0] outst, count;
   logic [NW:0]   inflight;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [2:0]    bit_idx;
   logic [7:0]    mem [FIFO_DEPTH];
   logic          accept, fetching, rd_req, rd_fire, push, pop, pvalid, pix_fire, poll_req, drained;
   logic          unused_hi;

   assign accept   = (state == IDLE) && start;
   assign fetching = (state == FETCH);
   // Outstanding reads plus buffered bytes never exceed the buffer, so every return has a slot.
   assign inflight = {1'b0, outst} + {1'b0, count};
   assign rd_req   = fetching && !issue_done && (inflight < (NW+1)'(FIFO_DEPTH));
   assign rd_fire  = rd_req && !bus.mwaitrequest;
   assign push     = fetching && bus.mreaddatavalid && (outst != '0);
   assign pvalid   = fetching && (count != '0);
   assign pix_fire = pvalid && bus.pix_ready;
   assign pop      = pix_fire && (bit_idx == 3'd7);
   assign drained  = issue_done && (outst == '0) && ((count == '0) || ((count == NW'(1)) && pop));
   assign unused_hi = &{1'b0, bus.mreaddata[31:8]};

`ifdef BITMAP_READER_STATUS_POLL_EN
   assign poll_req = (state == POLL_REQ);
`else
   assign poll_req = 1'b0;
`endif

   assign busy          = (state != IDLE);
   assign done          = (state == FINISH);
   assign bus.mread     = rd_req || poll_req;
   assign bus.maddress  = poll_req ? STATUS_ADDR : (rd_req ? {4'b0000, rd_row, rd_col} : 19'h0);
   assign bus.pix_valid = pvalid;
   assign bus.pix_data  = pvalid && mem[rd_ptr][bit_idx];
   assign bus.pix_sof   = pvalid && first_row && (out_col == 6'd0) && (bit_idx == 3'd0);
   assign bus.pix_eol   = pvalid && (out_col == LAST_COL) && (bit_idx == 3'd7);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (row_last < row_first) state_nx = FINISH;
`ifdef BITMAP_READER_STATUS_POLL_EN
               else                      state_nx = POLL_REQ;
`else
               else                      state_nx = FETCH;
`endif
            end
         end
`ifdef BITMAP_READER_STATUS_POLL_EN
         POLL_REQ:  if (!bus.mwaitrequest) state_nx = POLL_WAIT;
         POLL_WAIT: if (bus.mreaddatavalid)
                       state_nx = (bus.mreaddata[11:0] == 12'hFFF) ? FETCH : POLL_REQ;
`endif
         FETCH:     if (drained) state_nx = FINISH;
         FINISH:    state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Read address walk, outstanding/occupancy counters and unpacker position.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_row     <= '0;
         rd_col     <= '0;
         row_last_q <= '0;
         issue_done <= 1'b0;
         outst      <= '0;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         bit_idx    <= '0;
         out_col    <= '0;
         first_row  <= 1'b0;
      end else begin
         if (accept) begin
            rd_row     <= row_first;
            rd_col     <= '0;
            row_last_q <= row_last;
            issue_done <= 1'b0;
            bit_idx    <= '0;
            out_col    <= '0;
            first_row  <= 1'b1;
         end
         if (rd_fire) begin
            if (rd_col == LAST_COL) begin
               rd_col <= '0;
               rd_row <= rd_row + 1'b1;
               if (rd_row == row_last_q) issue_done <= 1'b1;
            end else begin
               rd_col <= rd_col + 1'b1;
            end
         end
         case ({rd_fire, push})
            2'b10:   outst <= outst + 1'b1;
            2'b01:   outst <= outst - 1'b1;
            default: outst <= outst;
         endcase
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         if (pix_fire) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
               if (out_col == LAST_COL) begin
                  out_col   <= '0;
                  first_row <= 1'b0;
               end else begin
                  out_col <= out_col + 1'b1;
               end
            end
         end
      end
   end

   // Byte storage; occupancy gates every read, so the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.mreaddata[7:0];
   end
endmodule
